// File: rtl/conv_result_buffer_pkg.sv
// Shared constants for the convolution result buffer: map geometry, widths
// and the state encodings used by the control FSM.
package conv_result_buffer_pkg;

    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 10;
    localparam int N_DEF    = ROWS_DEF * COLS_DEF;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 7;
    localparam int ROW_W  = 3;
    localparam int COL_W  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/conv_result_buffer_ram.sv
// Result storage: one write port and one registered read port; the read
// address is supplied a cycle early by the control logic.
module result_ram
    import conv_result_buffer_pkg::*;
#(
    parameter int DEPTH = N_DEF,
    parameter int AW    = ADDR_W
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  word_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output word_t         rdata_o
);

    word_t mem [DEPTH];
    word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_result_buffer.sv
// Captures one convolution output map, tracks its signed maximum, and replays
// it on a valid/ready stream with row/column tags.
module conv_result_buffer
    import conv_result_buffer_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_done,
    input  logic              clear,
    input  logic              rd_start,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              buf_full,
    output logic              busy,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] count,
    output logic              ovf_err,
    output logic              short_err
);

    localparam int              N        = ROWS * COLS;
    localparam logic [ADDR_W-1:0] N_CNT    = ADDR_W'(N);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    word_t             maxVal_q, maxVal_d;
    logic              ovfErr_q, ovfErr_d;
    logic              shortErr_q, shortErr_d;
    logic              outValid_q, outValid_d;
    logic [ADDR_W-1:0] rdIdx_q, rdIdx_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;

    logic              ramWe;
    logic [ADDR_W-1:0] ramWaddr;
    logic [ADDR_W-1:0] ramRaddr;
    word_t             ramRdata;
    logic [ADDR_W-1:0] fillCnt;
    logic              accept;
    logic              isLast;

    assign accept = outValid_q && out_ready;
    assign isLast = (rdIdx_q == count_q - ADDR_W'(1));

    // The RAM read address runs one element ahead on acceptance so the next
    // word is already registered when it must be presented.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        maxVal_d   = maxVal_q;
        ovfErr_d   = ovfErr_q;
        shortErr_d = shortErr_q;
        outValid_d = outValid_q;
        rdIdx_d    = rdIdx_q;
        row_d      = row_q;
        col_d      = col_q;
        ramWe      = 1'b0;
        ramWaddr   = count_q;
        ramRaddr   = rdIdx_q;
        fillCnt    = count_q;

        if (clear) begin
            state_d    = ST_IDLE;
            count_d    = '0;
            maxVal_d   = '0;
            ovfErr_d   = 1'b0;
            shortErr_d = 1'b0;
            outValid_d = 1'b0;
            rdIdx_d    = '0;
            row_d      = '0;
            col_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        ramWe    = 1'b1;
                        ramWaddr = '0;
                        count_d  = ADDR_W'(1);
                        maxVal_d = in_data;
                        state_d  = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        ramWe   = 1'b1;
                        fillCnt = count_q + ADDR_W'(1);
                        if ($signed(in_data) > $signed(maxVal_q)) begin
                            maxVal_d = in_data;
                        end
                    end
                    count_d = fillCnt;
                    // in_done is judged against the count after this cycle's write
                    if (fillCnt == N_CNT) begin
                        state_d = ST_FULL;
                    end else if (in_done) begin
                        state_d    = ST_FULL;
                        shortErr_d = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_valid) begin
                        ovfErr_d = 1'b1;
                    end
                    if (rd_start) begin
                        state_d    = ST_DRAIN;
                        outValid_d = 1'b1;
                        rdIdx_d    = '0;
                        row_d      = '0;
                        col_d      = '0;
                        ramRaddr   = '0;
                    end
                end
                default: begin
                    if (in_valid) begin
                        ovfErr_d = 1'b1;
                    end
                    if (accept) begin
                        if (isLast) begin
                            state_d    = ST_FULL;
                            outValid_d = 1'b0;
                        end else begin
                            rdIdx_d  = rdIdx_q + ADDR_W'(1);
                            ramRaddr = rdIdx_q + ADDR_W'(1);
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_q + ROW_W'(1);
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            maxVal_q   <= '0;
            ovfErr_q   <= 1'b0;
            shortErr_q <= 1'b0;
            outValid_q <= 1'b0;
            rdIdx_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            maxVal_q   <= maxVal_d;
            ovfErr_q   <= ovfErr_d;
            shortErr_q <= shortErr_d;
            outValid_q <= outValid_d;
            rdIdx_q    <= rdIdx_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    result_ram #(
        .DEPTH (N),
        .AW    (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ramWe),
        .waddr_i (ramWaddr),
        .wdata_i (in_data),
        .raddr_i (ramRaddr),
        .rdata_o (ramRdata)
    );

    // The read register has no reset, so data is masked whenever nothing is presented.
    assign out_data  = outValid_q ? ramRdata : '0;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_valid = outValid_q;
    assign out_last  = outValid_q && isLast;
    assign buf_full  = (state_q == ST_FULL) || (state_q == ST_DRAIN);
    assign busy      = (state_q == ST_FILL) || (state_q == ST_DRAIN);
    assign max_val   = maxVal_q;
    assign count     = count_q;
    assign ovf_err   = ovfErr_q;
    assign short_err = shortErr_q;

endmodule
